calc_entry_ctrl: RTL and testbench
==================================

# calc_entry_ctrl

Parametrised operand/operator entry controller for the keypad calculator. It replaces the externally sequenced entry FSM with a self-contained four-state controller. It accumulates two WIDTH-bit operands in hex or decimal radix, latches an operator, and runs a start/done handshake with the ALU. It sits between the debounced keypad decoder (one-cycle `boton` pulse plus 5-bit `valor` key code) and the ALU/VGA display path.

## Interface
- `WIDTH`, default 16: operand width in bits; must be at least 4.
- `clk`  in  1: system clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high; it has priority over every other input.
- `boton`  in  1: key strobe; each cycle it is high counts as one keypress of `valor`.
- `valor`  in  5: key code.
  - 0x00–0x0F: digits.
  - 0x10, 0x11, 0x12, 0x14, 0x15: operators.
  - 0x13: EXE.
  - 0x16: CE.
  - 0x17: AC.
  - 0x19: BKSP.
  - All other codes are ignored.
- `mode`  in  1: 0 = hex radix, 1 = decimal radix; sampled on every keypress.
- `alu_done`  in  1: ALU result valid; a one-cycle pulse.
- `operando1`, `operando2`  out  WIDTH: current operands.
- `operador`  out  5: latched operator code; 0x18 = none.
- `estado`  out  2: controller state, for display.
- `start`  out  1: one-cycle ALU launch pulse.
- `key_reject`  out  1: one-cycle pulse when a keypress is refused.

## Operation
- **R (radix):** R = 16 when `mode`=0, R = 10 when `mode`=1.
- **Digit accept rule:**
  - The candidate value is `op*R + d`, computed at WIDTH+4 bits.
  - The digit is accepted only when d < R and the candidate ≤ 2^WIDTH−1.
  - Otherwise the operand is unchanged and `key_reject` pulses.
- **BKSP:**
  - Sets op = op / R, using integer division (hex: shift right by 4; decimal: divide by 10).
  - On an operand that is already 0, the operand stays 0 and there is no reject.
- **States:** S_OP1 = 0, S_OP2 = 1, S_EXEC = 2, S_RES = 3. The current state is driven on `estado`.
- **S_OP1:**
  - Digit and BKSP edit `operando1`.
  - CE clears `operando1`.
  - An operator key latches `operador` and moves to S_OP2.
  - EXE is rejected.
- **S_OP2:**
  - Digit and BKSP edit `operando2`.
  - An operator key replaces `operador` and stays in S_OP2.
  - CE behaviour:
    - When `operando2` ≠ 0, CE clears `operando2`.
    - When `operando2` = 0, CE sets `operador` to 0x18 and returns to S_OP1; `operando1` is kept.
  - EXE asserts `start` for one cycle and moves to S_EXEC.
- **S_EXEC:**
  - Operands and operator are frozen.
  - `alu_done` moves to S_RES.
  - Every key except AC is rejected.
- **S_RES:**
  - EXE or CE clears both operands, sets `operador` to 0x18, and moves to S_OP1.
  - A digit key behaves the same way, except `operando1` is loaded with that digit (subject to the accept rule).
  - Operators and BKSP are rejected.
- **AC, in any state:**
  - Clears both operands.
  - Sets `operador` to 0x18.
  - Returns to S_OP1.
  - An AC issued in S_EXEC aborts the operation; a later `alu_done` is ignored.
- **Ignored inputs:** undefined codes produce no state change and no reject. `alu_done` outside S_EXEC is ignored.

## Timing
- **Reset values:** `operando1` = `operando2` = 0, `operador` = 0x18, `estado` = 0, `start` = 0, `key_reject` = 0.
- **Register latency:** all outputs are registered. An accepted keypress in cycle N is visible on `operando*`, `operador` and `estado` in cycle N+1.
- **Reject timing:** `key_reject` is high in cycle N+1 only.
- **Start timing:** EXE in S_OP2 at cycle N gives `start`=1 in cycle N+1 only and `estado`=2 in cycle N+1.
- **Done timing:** `alu_done` at cycle M in S_EXEC gives `estado`=3 in M+1. `alu_done` may arrive in the same cycle as the `start` pulse is high; it is accepted.
- **Simultaneous events:**
  - `reset` overrides a keypress.
  - AC overrides `alu_done` in the same cycle.
  - A keypress and `alu_done` in the same cycle in S_EXEC: the transition to S_RES happens and the key is rejected.
- **Back-to-back keys:** `boton` high on consecutive cycles is processed as consecutive keypresses, with no dead cycle.
- **Mode change:** toggling `mode` mid-entry does not convert the stored value. Only subsequent keypresses use the new radix.

## Test plan
1. **Hex entry:** reset; keys 1, 2, A, F → `operando1`=0x12AF. Key 3 → rejected (key_reject pulse), value unchanged. BKSP → 0x012A.
2. **Decimal entry, WIDTH=16:** keys 6, 5, 5, 3, 5 → 65535. Key 0 → rejected. Key 0xA in decimal on a fresh operand → rejected.
3. **Full operation:** 7, op 0x10, op 0x11 (replaces), 3, EXE → `start` pulses once and `estado`=2 with `operador`=0x11. `alu_done` → `estado`=3. Digit 5 → `operando1`=5, `operando2`=0, `operador`=0x18, `estado`=0.
4. **CE cascade in S_OP2:** `operando2`=0x42; CE → `operando2`=0; CE → `operador`=0x18, `estado`=0, `operando1` retained.
5. **Abort in S_EXEC:** AC in S_EXEC → all cleared, `estado`=0. A later `alu_done` → no change. A digit key in S_EXEC (without AC) → `key_reject` pulse.
6. **Reset priority and WIDTH=8 build:** reset asserted together with a digit key → reset values. WIDTH=8 hex: keys F, F → 0xFF; a further key 1 → rejected.

Source files
------------

// File: rtl/calc_entry_ctrl.sv
// Keypad calculator entry controller: accumulates two operands in hex or
// decimal radix, latches an operator and runs the start/done handshake
// with the ALU. All outputs are registered.
module calc_entry_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             boton,
  input  logic [4:0]       valor,
  input  logic             mode,
  input  logic             alu_done,
  output logic [WIDTH-1:0] operando1,
  output logic [WIDTH-1:0] operando2,
  output logic [4:0]       operador,
  output logic [1:0]       estado,
  output logic             start,
  output logic             key_reject
);

  localparam logic [1:0] S_OP1  = 2'd0;
  localparam logic [1:0] S_OP2  = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_RES  = 2'd3;

  localparam logic [4:0] OP_NONE = 5'h18;
  localparam logic [4:0] K_EXE   = 5'h13;
  localparam logic [4:0] K_CE    = 5'h16;
  localparam logic [4:0] K_AC    = 5'h17;
  localparam logic [4:0] K_BKSP  = 5'h19;

  // op*R + d at WIDTH+4 bits; the x10 product is built from shifts.
  function automatic logic [WIDTH+3:0] digit_cand(input logic [WIDTH-1:0] op,
                                                  input logic [3:0] d,
                                                  input logic dec);
    logic [WIDTH+3:0] wide;
    logic [WIDTH+3:0] dext;
    wide = {4'b0000, op};
    dext = {{WIDTH{1'b0}}, d};
    if (dec) digit_cand = (wide << 3) + (wide << 1) + dext;
    else     digit_cand = (wide << 4) + dext;
  endfunction

  // A digit is legal for the radix and the result still fits in WIDTH bits.
  function automatic logic digit_fits(input logic [WIDTH+3:0] cand,
                                      input logic [3:0] d,
                                      input logic dec);
    digit_fits = (!dec || (d < 4'd10)) && (cand[WIDTH+3:WIDTH] == 4'd0);
  endfunction

  // Drop the least significant digit in the current radix.
  function automatic logic [WIDTH-1:0] backspace(input logic [WIDTH-1:0] op,
                                                 input logic dec);
    if (dec) backspace = op / WIDTH'(10);
    else     backspace = op >> 4;
  endfunction

  logic [1:0]       state, state_n;
  logic [WIDTH-1:0] op1_n, op2_n;
  logic [4:0]       opr_n;
  logic             start_n, rej_n;

  logic is_digit, is_oper, is_exe, is_ce, is_ac, is_bksp, is_known;
  logic [3:0]       d;
  logic [WIDTH+3:0] cand1, cand2;
  logic             fit1, fit2, d_ok;

  assign d        = valor[3:0];
  assign is_digit = boton && !valor[4];
  assign is_oper  = boton && ((valor == 5'h10) || (valor == 5'h11) || (valor == 5'h12) ||
                              (valor == 5'h14) || (valor == 5'h15));
  assign is_exe   = boton && (valor == K_EXE);
  assign is_ce    = boton && (valor == K_CE);
  assign is_ac    = boton && (valor == K_AC);
  assign is_bksp  = boton && (valor == K_BKSP);
  assign is_known = is_digit || is_oper || is_exe || is_ce || is_ac || is_bksp;

  assign cand1 = digit_cand(operando1, d, mode);
  assign cand2 = digit_cand(operando2, d, mode);
  assign fit1  = digit_fits(cand1, d, mode);
  assign fit2  = digit_fits(cand2, d, mode);
  // Starting from a cleared operand only the radix check can fail (WIDTH >= 4).
  assign d_ok  = !mode || (d < 4'd10);

  assign estado = state;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_OP1;
    else       state <= state_n;
  end

  // Next-state logic; AC wins over every other event including alu_done.
  always_comb begin
    state_n = state;
    if (is_ac) begin
      state_n = S_OP1;
    end else begin
      unique case (state)
        S_OP1:  if (is_oper) state_n = S_OP2;
        S_OP2: begin
          if (is_exe)                             state_n = S_EXEC;
          else if (is_ce && (operando2 == '0))    state_n = S_OP1;
        end
        S_EXEC: if (alu_done) state_n = S_RES;
        S_RES:  if (is_exe || is_ce || (is_digit && d_ok)) state_n = S_OP1;
        default: state_n = S_OP1;
      endcase
    end
  end

  // Next values of operands, operator and the start/reject pulses.
  always_comb begin
    op1_n   = operando1;
    op2_n   = operando2;
    opr_n   = operador;
    start_n = 1'b0;
    rej_n   = 1'b0;
    if (is_ac) begin
      op1_n = '0;
      op2_n = '0;
      opr_n = OP_NONE;
    end else begin
      unique case (state)
        S_OP1: begin
          if (is_digit) begin
            if (fit1) op1_n = cand1[WIDTH-1:0];
            else      rej_n = 1'b1;
          end
          if (is_bksp) op1_n = backspace(operando1, mode);
          if (is_ce)   op1_n = '0;
          if (is_oper) opr_n = valor;
          if (is_exe)  rej_n = 1'b1;
        end
        S_OP2: begin
          if (is_digit) begin
            if (fit2) op2_n = cand2[WIDTH-1:0];
            else      rej_n = 1'b1;
          end
          if (is_bksp) op2_n = backspace(operando2, mode);
          if (is_oper) opr_n = valor;
          if (is_ce) begin
            if (operando2 != '0) op2_n = '0;
            else                 opr_n = OP_NONE;
          end
          if (is_exe) start_n = 1'b1;
        end
        S_EXEC: begin
          // Operands are frozen while the ALU works; only AC gets through.
          if (is_known) rej_n = 1'b1;
        end
        S_RES: begin
          if (is_exe || is_ce) begin
            op1_n = '0;
            op2_n = '0;
            opr_n = OP_NONE;
          end
          if (is_digit) begin
            if (d_ok) begin
              op1_n = WIDTH'(d);
              op2_n = '0;
              opr_n = OP_NONE;
            end else begin
              rej_n = 1'b1;
            end
          end
          if (is_oper || is_bksp) rej_n = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      operando1  <= '0;
      operando2  <= '0;
      operador   <= OP_NONE;
      start      <= 1'b0;
      key_reject <= 1'b0;
    end else begin
      operando1  <= op1_n;
      operando2  <= op2_n;
      operador   <= opr_n;
      start      <= start_n;
      key_reject <= rej_n;
    end
  end

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Bench for calc_entry_ctrl: a 16-bit and an 8-bit instance share one input
// stream and are compared every cycle against a behavioural model.
module tb_calc_entry_ctrl;

  logic       clk = 1'b0;
  logic       reset, boton, mode, alu_done;
  logic [4:0] valor;

  logic [15:0] a_op1, a_op2;
  logic [7:0]  b_op1, b_op2;
  logic [4:0]  a_opr, b_opr;
  logic [1:0]  a_st, b_st;
  logic        a_start, b_start, a_rej, b_rej;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state, index 0 = WIDTH 16, index 1 = WIDTH 8.
  longint m_op1[2], m_op2[2];
  int     m_opr[2], m_st[2];
  bit     m_start[2], m_rej[2];

  calc_entry_ctrl #(.WIDTH(16)) dut_a (
    .clk(clk), .reset(reset), .boton(boton), .valor(valor), .mode(mode),
    .alu_done(alu_done), .operando1(a_op1), .operando2(a_op2),
    .operador(a_opr), .estado(a_st), .start(a_start), .key_reject(a_rej));

  calc_entry_ctrl #(.WIDTH(8)) dut_b (
    .clk(clk), .reset(reset), .boton(boton), .valor(valor), .mode(mode),
    .alu_done(alu_done), .operando1(b_op1), .operando2(b_op2),
    .operador(b_opr), .estado(b_st), .start(b_start), .key_reject(b_rej));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour for one clock, from the current inputs.
  task automatic model(input int i, input int w);
    longint maxv;
    int     r, v;
    bit     known, oper;
    maxv = (longint'(1) << w) - 1;
    r    = mode ? 10 : 16;
    v    = int'(valor);
    oper  = (v == 'h10) || (v == 'h11) || (v == 'h12) || (v == 'h14) || (v == 'h15);
    known = (v < 16) || oper || (v == 'h13) || (v == 'h16) || (v == 'h17) || (v == 'h19);
    m_start[i] = 0;
    m_rej[i]   = 0;
    if (reset || (boton && v == 'h17)) begin
      m_op1[i] = 0; m_op2[i] = 0; m_opr[i] = 'h18; m_st[i] = 0;
      return;
    end
    case (m_st[i])
      0: if (boton) begin
        if (v < 16) begin
          if (v < r && m_op1[i] * r + v <= maxv) m_op1[i] = m_op1[i] * r + v;
          else m_rej[i] = 1;
        end else if (v == 'h19) m_op1[i] = m_op1[i] / r;
        else if (v == 'h16) m_op1[i] = 0;
        else if (oper) begin m_opr[i] = v; m_st[i] = 1; end
        else if (v == 'h13) m_rej[i] = 1;
      end
      1: if (boton) begin
        if (v < 16) begin
          if (v < r && m_op2[i] * r + v <= maxv) m_op2[i] = m_op2[i] * r + v;
          else m_rej[i] = 1;
        end else if (v == 'h19) m_op2[i] = m_op2[i] / r;
        else if (oper) m_opr[i] = v;
        else if (v == 'h16) begin
          if (m_op2[i] != 0) m_op2[i] = 0;
          else begin m_opr[i] = 'h18; m_st[i] = 0; end
        end else if (v == 'h13) begin m_start[i] = 1; m_st[i] = 2; end
      end
      2: begin
        if (boton && known) m_rej[i] = 1;
        if (alu_done) m_st[i] = 3;
      end
      default: if (boton) begin
        if (v == 'h13 || v == 'h16) begin
          m_op1[i] = 0; m_op2[i] = 0; m_opr[i] = 'h18; m_st[i] = 0;
        end else if (v < 16) begin
          if (v < r) begin
            m_op1[i] = v; m_op2[i] = 0; m_opr[i] = 'h18; m_st[i] = 0;
          end else m_rej[i] = 1;
        end else if (known) m_rej[i] = 1;
      end
    endcase
  endtask

  task automatic compare_all();
    check("a_op1",   32'(a_op1),   32'(m_op1[0]));
    check("a_op2",   32'(a_op2),   32'(m_op2[0]));
    check("a_opr",   32'(a_opr),   32'(m_opr[0]));
    check("a_st",    32'(a_st),    32'(m_st[0]));
    check("a_start", 32'(a_start), 32'(m_start[0]));
    check("a_rej",   32'(a_rej),   32'(m_rej[0]));
    check("b_op1",   32'(b_op1),   32'(m_op1[1]));
    check("b_op2",   32'(b_op2),   32'(m_op2[1]));
    check("b_opr",   32'(b_opr),   32'(m_opr[1]));
    check("b_st",    32'(b_st),    32'(m_st[1]));
    check("b_start", 32'(b_start), 32'(m_start[1]));
    check("b_rej",   32'(b_rej),   32'(m_rej[1]));
  endtask

  // Apply inputs for one clock, then compare just after the edge.
  task automatic cycle(input logic b, input logic [4:0] v, input logic m,
                       input logic d, input logic r);
    boton = b; valor = v; mode = m; alu_done = d; reset = r;
    @(posedge clk);
    #1;
    model(0, 16);
    model(1, 8);
    compare_all();
  endtask

  task automatic key(input logic [4:0] v);
    cycle(1'b1, v, mode, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic d);
    cycle(1'b0, 5'h00, mode, d, 1'b0);
  endtask

  initial begin
    reset = 1'b1; boton = 1'b0; valor = '0; mode = 1'b0; alu_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_op1[i] = 0; m_op2[i] = 0; m_opr[i] = 'h18; m_st[i] = 0;
      m_start[i] = 0; m_rej[i] = 0;
    end
    #1;
    cycle(1'b0, 5'h00, 1'b0, 1'b0, 1'b1);
    check("rst_opr", 32'(a_opr), 32'h18);
    check("rst_op1", 32'(a_op1), 32'h0);

    // Hex entry
    key(5'h01); key(5'h02); key(5'h0A); key(5'h0F);
    check("hex_12af", 32'(a_op1), 32'h12AF);
    key(5'h03);
    check("hex_ovf_rej", 32'(a_rej), 32'h1);
    check("hex_ovf_keep", 32'(a_op1), 32'h12AF);
    key(5'h19);
    check("hex_bksp", 32'(a_op1), 32'h012A);
    idle(1'b0);

    // Decimal entry
    key(5'h17); mode = 1'b1;
    key(5'h06); key(5'h05); key(5'h05); key(5'h03); key(5'h05);
    check("dec_65535", 32'(a_op1), 32'd65535);
    key(5'h00);
    check("dec_ovf_rej", 32'(a_rej), 32'h1);
    key(5'h17); key(5'h0A);
    check("dec_a_rej", 32'(a_rej), 32'h1);

    // Full operation
    key(5'h17); mode = 1'b0;
    key(5'h07); key(5'h10); key(5'h11); key(5'h03); key(5'h13);
    check("exe_start", 32'(a_start), 32'h1);
    check("exe_state", 32'(a_st), 32'h2);
    check("exe_opr", 32'(a_opr), 32'h11);
    idle(1'b0);
    check("start_once", 32'(a_start), 32'h0);
    idle(1'b1);
    check("done_state", 32'(a_st), 32'h3);
    key(5'h05);
    check("res_digit_op1", 32'(a_op1), 32'h5);
    check("res_digit_opr", 32'(a_opr), 32'h18);

    // CE cascade
    key(5'h17); key(5'h01); key(5'h10); key(5'h04); key(5'h02);
    check("ce_op2_42", 32'(a_op2), 32'h42);
    key(5'h16);
    check("ce1_op2", 32'(a_op2), 32'h0);
    key(5'h16);
    check("ce2_state", 32'(a_st), 32'h0);
    check("ce2_op1", 32'(a_op1), 32'h1);

    // Abort and reject in S_EXEC, done in same cycle as start
    key(5'h02); key(5'h10); key(5'h03); key(5'h13);
    key(5'h17);
    check("abort_state", 32'(a_st), 32'h0);
    idle(1'b1);
    check("late_done", 32'(a_st), 32'h0);
    key(5'h10); key(5'h03); key(5'h13);
    key(5'h05);
    check("exec_key_rej", 32'(a_rej), 32'h1);
    cycle(1'b1, 5'h17, mode, 1'b1, 1'b0);
    check("ac_over_done", 32'(a_st), 32'h0);
    key(5'h10); key(5'h13); idle(1'b1);
    check("done_with_start", 32'(a_st), 32'h3);
    cycle(1'b1, 5'h04, mode, 1'b0, 1'b0);

    // Reset priority and 8-bit limit
    cycle(1'b1, 5'h05, 1'b0, 1'b0, 1'b1);
    check("rst_key_op1", 32'(a_op1), 32'h0);
    key(5'h0F); key(5'h0F);
    check("w8_ff", 32'(b_op1), 32'hFF);
    key(5'h01);
    check("w8_rej", 32'(b_rej), 32'h1);

    // Randomised traffic
    for (int n = 0; n < 4000; n++) begin
      logic       b, dn, rs, m;
      logic [4:0] v;
      int         sel;
      b   = ($urandom_range(0, 99) < 70);
      sel = $urandom_range(0, 99);
      if (sel < 50)      v = 5'($urandom_range(0, 15));
      else if (sel < 65) v = 5'($urandom_range(16, 18));
      else if (sel < 72) v = 5'($urandom_range(20, 21));
      else if (sel < 80) v = 5'h13;
      else if (sel < 87) v = 5'h16;
      else if (sel < 90) v = 5'h17;
      else if (sel < 96) v = 5'h19;
      else               v = 5'($urandom_range(24, 31));
      m  = ($urandom_range(0, 99) < 5) ? ~mode : mode;
      dn = ($urandom_range(0, 99) < 15);
      rs = ($urandom_range(0, 299) == 0);
      cycle(b, v, m, dn, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
